// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot controller: gate-sequence state codes,
// default lot sizing, and the sensor pattern each state expects to see.
package parking_pkg;

    localparam int DEF_CAPACITY = 32;
    localparam int DEF_CNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EN_A  = 3'd1,
        ST_EN_AB = 3'd2,
        ST_EN_B  = 3'd3,
        ST_EX_B  = 3'd4,
        ST_EX_AB = 3'd5,
        ST_EX_A  = 3'd6,
        ST_ERR   = 3'd7
    } gate_state_e;

    // AB pattern that keeps a state where it is; ERR has no fixed pattern.
    function automatic logic [1:0] implied_ab(input logic [2:0] st);
        logic [1:0] ab;
        case (st)
            3'd0:    ab = 2'b00;
            3'd1:    ab = 2'b10;
            3'd2:    ab = 2'b11;
            3'd3:    ab = 2'b01;
            3'd4:    ab = 2'b01;
            3'd5:    ab = 2'b11;
            3'd6:    ab = 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with registered full/empty flags and a
// one-cycle pulse when a step would leave the range [0, CAPACITY].
module occupancy_counter import parking_pkg::*; #(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_unf
);

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             ovf_unf_r;
    logic             ovf_unf_nxt_s;

    // Next count: a step that would cross either bound is refused and flagged.
    always_comb begin
        count_nxt_s   = count_r;
        ovf_unf_nxt_s = 1'b0;
        if (inc && !dec) begin
            if (count_r < CAP_C) begin
                count_nxt_s = count_r + ONE_C;
            end else begin
                ovf_unf_nxt_s = 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_r != ZERO_C) begin
                count_nxt_s = count_r - ONE_C;
            end else begin
                ovf_unf_nxt_s = 1'b1;
            end
        end else begin
            count_nxt_s   = count_r;
            ovf_unf_nxt_s = 1'b0;
        end
    end

    // Flags are registered from the next count so they track count in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= ZERO_C;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            ovf_unf_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            full_r    <= (count_nxt_s == CAP_C);
            empty_r   <= (count_nxt_s == ZERO_C);
            ovf_unf_r <= ovf_unf_nxt_s;
        end
    end

    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign ovf_unf = ovf_unf_r;

endmodule

// File: rtl/parking_gate_fsm.sv
// Gate direction decoder: tracks the outer/inner beam sequence, counts completed
// entries and exits, and flags illegal transitions and count overflow/underflow.
module parking_gate_fsm import parking_pkg::*; #(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_a,
    input  logic             sens_b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             car_in,
    output logic             car_out,
    output logic             seq_err
);

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_EN_A  = 3'(ST_EN_A);
    localparam logic [2:0] S_EN_AB = 3'(ST_EN_AB);
    localparam logic [2:0] S_EN_B  = 3'(ST_EN_B);
    localparam logic [2:0] S_EX_B  = 3'(ST_EX_B);
    localparam logic [2:0] S_EX_AB = 3'(ST_EX_AB);
    localparam logic [2:0] S_EX_A  = 3'(ST_EX_A);
    localparam logic [2:0] S_ERR   = 3'(ST_ERR);

    logic [1:0]       ab_s;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             inc_s;
    logic             dec_s;
    logic             ill_s;
    logic             ill_r;
    logic             car_in_r;
    logic             car_out_r;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             ovf_unf_s;

    assign ab_s = {sens_a, sens_b};

    // Transition decode: single-bit moves advance or reverse, two-bit jumps are illegal.
    always_comb begin
        state_nxt_s = state_r;
        inc_s       = 1'b0;
        dec_s       = 1'b0;
        ill_s       = 1'b0;
        if ((state_r != S_ERR) && (ab_s == implied_ab(state_r))) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ab_s == 2'b10)      state_nxt_s = S_EN_A;
                    else if (ab_s == 2'b01) state_nxt_s = S_EX_B;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EN_A: begin
                    if (ab_s == 2'b11)      state_nxt_s = S_EN_AB;
                    else if (ab_s == 2'b00) state_nxt_s = S_IDLE;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EN_AB: begin
                    if (ab_s == 2'b01)      state_nxt_s = S_EN_B;
                    else if (ab_s == 2'b10) state_nxt_s = S_EN_A;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EN_B: begin
                    if (ab_s == 2'b00)      begin state_nxt_s = S_IDLE; inc_s = 1'b1; end
                    else if (ab_s == 2'b11) state_nxt_s = S_EN_AB;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EX_B: begin
                    if (ab_s == 2'b11)      state_nxt_s = S_EX_AB;
                    else if (ab_s == 2'b00) state_nxt_s = S_IDLE;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EX_AB: begin
                    if (ab_s == 2'b10)      state_nxt_s = S_EX_A;
                    else if (ab_s == 2'b01) state_nxt_s = S_EX_B;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_EX_A: begin
                    if (ab_s == 2'b00)      begin state_nxt_s = S_IDLE; dec_s = 1'b1; end
                    else if (ab_s == 2'b11) state_nxt_s = S_EX_AB;
                    else begin state_nxt_s = S_ERR; ill_s = 1'b1; end
                end
                S_ERR: begin
                    if (ab_s == 2'b00) state_nxt_s = S_IDLE;
                    else               state_nxt_s = S_ERR;
                end
                default: state_nxt_s = S_ERR;
            endcase
        end
    end

    // State and event pulses; a completion at a count bound is reported by the counter instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            ill_r     <= 1'b0;
            car_in_r  <= 1'b0;
            car_out_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ill_r     <= ill_s;
            car_in_r  <= inc_s & ~full_s;
            car_out_r <= dec_s & ~empty_s;
        end
    end

    occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc_s),
        .dec     (dec_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s),
        .ovf_unf (ovf_unf_s)
    );

    assign count   = count_s;
    assign full    = full_s;
    assign empty   = empty_s;
    assign car_in  = car_in_r;
    assign car_out = car_out_r;
    assign seq_err = ill_r | ovf_unf_s;

endmodule

// File: tb/tb_parking_gate_fsm.sv
// Directed bench for parking_gate_fsm with a path-position model of car movement
// through the gate, checked every cycle, plus hand-computed literal expectations.
module tb_parking_gate_fsm;

    localparam int CAP = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sens_a;
    logic          sens_b;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          car_in;
    logic          car_out;
    logic          seq_err;

    int total = 0;
    int bad   = 0;
    int n_in  = 0;
    int n_out = 0;
    int n_err = 0;
    int b_in, b_out, b_err;

    parking_gate_fsm #(.CAPACITY(CAP), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sens_a  (sens_a),
        .sens_b  (sens_b),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .car_in  (car_in),
        .car_out (car_out),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    // Model: dir 0 = idle, 1 = entering, 2 = exiting, 3 = error; pos = steps along the path.
    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] pos;
        logic [7:0] cnt;
        logic       cin;
        logic       cout;
        logic       err;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(input mstate_t s, input logic [1:0] ab);
        mstate_t    n;
        logic [1:0] path [0:3];
        n      = s;
        n.cin  = 1'b0;
        n.cout = 1'b0;
        n.err  = 1'b0;
        if (s.dir == 2'd3) begin
            if (ab == 2'b00) n.dir = 2'd0;
            return n;
        end
        if (s.dir == 2'd0) begin
            if (ab == 2'b10)      begin n.dir = 2'd1; n.pos = 2'd1; end
            else if (ab == 2'b01) begin n.dir = 2'd2; n.pos = 2'd1; end
            else if (ab == 2'b11) begin n.dir = 2'd3; n.err = 1'b1; end
            return n;
        end
        path[0] = 2'b00;
        path[2] = 2'b11;
        path[1] = (s.dir == 2'd1) ? 2'b10 : 2'b01;
        path[3] = (s.dir == 2'd1) ? 2'b01 : 2'b10;
        if (ab == path[s.pos]) return n;
        if (s.pos < 2'd3 && ab == path[s.pos + 2'd1]) begin
            n.pos = s.pos + 2'd1;
        end else if (ab == path[s.pos - 2'd1]) begin
            n.pos = s.pos - 2'd1;
            if (s.pos == 2'd1) n.dir = 2'd0;
        end else if (s.pos == 2'd3 && ab == 2'b00) begin
            n.dir = 2'd0;
            n.pos = 2'd0;
            if (s.dir == 2'd1) begin
                if (int'(s.cnt) < CAP) begin n.cnt = s.cnt + 8'd1; n.cin = 1'b1; end
                else n.err = 1'b1;
            end else begin
                if (s.cnt > 8'd0) begin n.cnt = s.cnt - 8'd1; n.cout = 1'b1; end
                else n.err = 1'b1;
            end
        end else begin
            n.dir = 2'd3;
            n.pos = 2'd0;
            n.err = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= step(m, {sens_a, sens_b});
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        chk("count",   int'(count),   int'(m.cnt));
        chk("full",    int'(full),    int'(int'(m.cnt) == CAP));
        chk("empty",   int'(empty),   int'(m.cnt == 8'd0));
        chk("car_in",  int'(car_in),  int'(m.cin));
        chk("car_out", int'(car_out), int'(m.cout));
        chk("seq_err", int'(seq_err), int'(m.err));
        n_in  += int'(car_in);
        n_out += int'(car_out);
        n_err += int'(seq_err);
    endtask

    task automatic hold(input logic [1:0] ab, input int cycles);
        {sens_a, sens_b} = ab;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            cmp_cycle();
        end
    endtask

    task automatic entry(input int c);
        hold(2'b00, c); hold(2'b10, c); hold(2'b11, c); hold(2'b01, c); hold(2'b00, c);
    endtask

    task automatic exit_car(input int c);
        hold(2'b00, c); hold(2'b01, c); hold(2'b11, c); hold(2'b10, c); hold(2'b00, c);
    endtask

    task automatic snap();
        b_in  = n_in;
        b_out = n_out;
        b_err = n_err;
    endtask

    initial begin
        rst    = 1'b0;
        sens_a = 1'b0;
        sens_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cycle();
        end
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        rst = 1'b1;

        snap();
        entry(5);
        chk("entry1_in", n_in - b_in, 1);
        chk("entry1_count", int'(count), 1);
        chk("entry1_empty", int'(empty), 0);

        entry(3);
        entry(3);
        snap();
        exit_car(3);
        chk("exit_out", n_out - b_out, 1);
        chk("exit_count", int'(count), 2);

        exit_car(3);
        exit_car(3);
        snap();
        exit_car(3);
        chk("unf_err", n_err - b_err, 1);
        chk("unf_out", n_out - b_out, 0);
        chk("unf_count", int'(count), 0);
        chk("model_unf_count", int'(m.cnt), 0);

        snap();
        hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 3);
        chk("abort_pulses", (n_in - b_in) + (n_out - b_out) + (n_err - b_err), 0);
        chk("abort_count", int'(count), 0);

        snap();
        hold(2'b10, 3); hold(2'b01, 20);
        chk("illegal_err", n_err - b_err, 1);
        hold(2'b00, 3);
        entry(3);
        chk("after_err_in", n_in - b_in, 1);
        chk("after_err_count", int'(count), 1);

        entry(3); entry(3); entry(3);
        chk("fill_count", int'(count), 4);
        chk("fill_full", int'(full), 1);
        snap();
        entry(3);
        chk("ovf_err", n_err - b_err, 1);
        chk("ovf_in", n_in - b_in, 0);
        chk("ovf_count", int'(count), 4);
        chk("model_ovf_count", int'(m.cnt), 4);

        exit_car(3);
        exit_car(3);
        chk("pre_rst_count", int'(count), 2);
        hold(2'b10, 3); hold(2'b11, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmp_cycle();
        end
        rst = 1'b1;
        snap();
        hold(2'b11, 4);
        chk("release11_err", n_err - b_err, 1);
        hold(2'b00, 3);
        entry(3);
        chk("post_rst_count", int'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_fsm.md
# parking_gate_fsm

Direction-decoding and occupancy-counting stage for the parking-lot controller. It consumes the debounced outputs of two gate photo-sensors: outer beam A, then inner beam B, both already synchronous to `clk`. It recognises complete entry and exit sequences, rejects aborted and illegal ones, and maintains the occupied-space count, full/empty flags and one-cycle event pulses for the display and barrier logic.

## Interface
- `CAPACITY`, default 32: number of spaces; count saturates here.
- `CNT_W`, default 6: width of the count; must satisfy 2^CNT_W > CAPACITY.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset (asserts on falling edge, releases synchronously to `clk` by upstream reset logic).
- `sens_a`  in  1  debounced outer-beam state, 1 = beam blocked.
- `sens_b`  in  1  debounced inner-beam state, 1 = beam blocked.
- `count`  out  CNT_W  occupied spaces.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `car_in`  out  1  one-cycle pulse: valid entry counted.
- `car_out`  out  1  one-cycle pulse: valid exit counted.
- `seq_err`  out  1  one-cycle pulse: illegal sensor transition, overflow or underflow.

## Operation
- Sensor pair sampled each cycle as AB (2 bits). The FSM moves only when AB differs from the value implied by the current state; otherwise it holds.
- States and AB values implied: IDLE (00), EN_A (10), EN_AB (11), EN_B (01), EX_B (01), EX_AB (11), EX_A (10), ERR (any).
- IDLE: 10 goes to EN_A; 01 goes to EX_B; 11 goes to ERR.
- Entry path, forward:
  - EN_A on 11 goes to EN_AB.
  - EN_AB on 01 goes to EN_B.
  - EN_B on 00 completes the entry and returns to IDLE.
- Entry path, reversals (car backs out), no count change:
  - EN_B on 11 goes to EN_AB.
  - EN_AB on 10 goes to EN_A.
  - EN_A on 00 goes to IDLE.
- Exit path: mirror image of the entry path with A and B swapped. EX_A on 00 completes the exit.
- Any other change (a jump of two bits, e.g. EN_A to 01, or EN_AB to 00) goes to ERR and pulses `seq_err`.
- ERR: stays until AB = 00, then returns to IDLE. Only the entry edge into ERR produces a pulse.
- Entry completion:
  - `count < CAPACITY`: count +1 and `car_in` pulses.
  - Otherwise: count unchanged and `seq_err` pulses (overflow).
- Exit completion:
  - `count > 0`: count −1 and `car_out` pulses.
  - Otherwise: count unchanged and `seq_err` pulses (underflow).
- At most one of `car_in`, `car_out`, `seq_err` is high in any cycle.
- Arithmetic is unsigned CNT_W. Count never wraps; it is bounded in [0, CAPACITY].

## Timing
- All outputs are registered. On reset: state IDLE, `count` = 0, `empty` = 1, `full` = 0, all pulses 0.
- Latency: the edge that samples the completing AB = 00 updates `count` and raises the pulse. The pulse stays high for exactly that one cycle. `full`/`empty` reflect the new count in the same cycle.
- Reset mid-sequence: the partial sequence is discarded and the count is cleared. After release with AB ≠ 00, IDLE transitions from the current AB as in normal operation; AB = 11 at release goes to ERR.
- A held, stable AB never produces repeated pulses.

## Structure
- Shared package `parking_pkg`:
  - state enum (8 codes, 3-bit).
  - default `CAPACITY` and `CNT_W` constants, reused by the display and barrier blocks.
- One natural sub-module: `occupancy_counter`, a saturating up/down counter.
  - Inputs: inc, dec (mutually exclusive).
  - Outputs: count, full, empty, and an ovf/unf pulse.
- The FSM drives inc/dec; the block ORs ovf/unf into `seq_err`.
- The debouncers for `sens_a`/`sens_b` are instantiated at the top level, not inside this block.

## Test plan
- Reset, then AB = 00, 10, 11, 01, 00, each held 5 cycles: one `car_in` pulse on the final 00 edge; `count` = 1; `empty` falls the same cycle.
- From `count` = 3, AB = 00, 01, 11, 10, 00: one `car_out` pulse; `count` = 2. Repeat from `count` = 0: `seq_err` pulse, `count` stays 0, no `car_out`.
- Aborted entry, AB = 10, 11, 10, 00: no pulses; state back to IDLE; `count` unchanged.
- Illegal jump, AB = 10, then 01 directly: a single `seq_err` pulse. Holding 01 for 20 cycles gives no further pulses. Then 00 returns to IDLE, and a following valid entry counts.
- With `CAPACITY` = 4: five valid entries give `count` = 4, `full` = 1 after the fourth, and a `seq_err` pulse (not `car_in`) on the fifth.
- Drop `rst` low while in EN_AB with `count` = 2: asynchronous clear gives `count` = 0 and IDLE. Release with AB = 11: enters ERR and pulses `seq_err`.
